// File: rtl/ram_burst_pkg.sv
// Shared types and sizing for the RAM burst controller and its 32x8 RAM.
package ram_burst_pkg;

    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int DEPTH   = 32;
    localparam int MAX_LEN = 32;
    localparam int LW      = 6;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_t;

    function automatic logic len_legal(input logic [LW-1:0] l);
        return (l != '0) && (l <= LW'(MAX_LEN));
    endfunction

endpackage

// File: rtl/RAM32B.sv
// 32x8 synchronous RAM: write when wr_rd=1, registered read with one cycle of latency.
module RAM32B
    import ram_burst_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_rd,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_rd) begin
            mem[addr] <= data_in;
        end
        data_out <= mem[addr];
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer between a write stream, a read stream and a 32x8 single-port RAM.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start; an illegal len raises a one-cycle err
//   WRITE    | s_ready high; every s_valid cycle writes one beat to the RAM
//   RD_ISSUE | present the read address to the RAM
//   RD_WAIT  | RAM data returns; capture it into m_data
//   RD_HOLD  | m_valid high until the consumer takes the beat
//   DONE     | one-cycle done pulse, then back to IDLE
module ram_burst_ctrl
    import ram_burst_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr_rd,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] base_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt_q;
    logic [DW-1:0] m_data_q;
    logic          err_q;
    logic          accept;
    logic          last_beat;

    assign accept    = start && len_legal(len);
    assign last_beat = (cnt_q + LW'(1)) == len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = dir ? WRITE : RD_ISSUE;
            WRITE:    if (s_valid && last_beat) state_nxt = DONE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RD_HOLD;
            RD_HOLD:  if (m_ready) state_nxt = last_beat ? DONE : RD_ISSUE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The beat counter only advances on an accepted beat, so stalls on
    // either stream leave the RAM address where it was.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            m_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && !len_legal(len);
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_q <= base_addr;
                        len_q  <= len;
                        cnt_q  <= '0;
                    end
                end
                WRITE:   if (s_valid) cnt_q <= cnt_q + LW'(1);
                RD_WAIT: m_data_q <= ram_data_out;
                RD_HOLD: if (m_ready) cnt_q <= cnt_q + LW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready     = 1'b0;
        ram_wr_rd   = 1'b0;
        ram_data_in = '0;
        m_valid     = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            WRITE: begin
                s_ready     = 1'b1;
                ram_wr_rd   = s_valid;
                ram_data_in = s_valid ? s_data : '0;
            end
            RD_HOLD: m_valid = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    assign ram_addr = base_q + cnt_q[AW-1:0];
    assign m_data   = m_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench: burst controller driving a RAM32B, checked against an array model of memory.
module tb_ram_burst_ctrl;
    import ram_burst_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dir;
    logic [4:0] base_addr;
    logic [5:0] len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] ram_addr;
    logic       ram_wr_rd;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;
    logic       busy;
    logic       done;
    logic       err;

    ram_burst_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_addr(ram_addr), .ram_wr_rd(ram_wr_rd), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .busy(busy), .done(done), .err(err)
    );

    RAM32B u_ram (
        .clk(clk), .addr(ram_addr), .wr_rd(ram_wr_rd), .data_in(ram_data_in), .data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         exp_done = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] model [32];
    logic [7:0] wdata [$];
    wr_t        wq [$];
    logic [7:0] rq [$];
    wr_t        e_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event with nothing expected at %0t", name, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every RAM write and every presented read beat must match the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (ram_wr_rd) begin
            if (wq.size() == 0) begin
                fail("unexpected_write");
            end else begin
                e_w = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e_w.a));
                chk("wr_data", 32'(ram_data_in), 32'(e_w.d));
            end
        end
        if (m_valid) begin
            if (rq.size() == 0) begin
                fail("unexpected_read");
            end else begin
                chk("rd_data", 32'(m_data), 32'(rq[0]));
                if (m_ready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic d, input logic [4:0] b, input logic [5:0] l);
        start     = 1'b1;
        dir       = d;
        base_addr = b;
        len       = l;
        step();
        start     = 1'b0;
        base_addr = 5'($urandom);
        len       = 6'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (done_cnt < exp_done && cycles < budget) begin
            step();
            cycles++;
        end
        chk(name, done_cnt, exp_done);
    endtask

    task automatic write_burst(input logic [4:0] b, input int l, input int gap_after,
                               input int gap_len, input bit rand_gaps);
        int cyc;
        int a;
        issue(1'b1, b, 6'(l));
        exp_done++;
        for (int i = 0; i < l; i++) begin
            a       = (int'(b) + i) % DEPTH;
            s_valid = 1'b1;
            s_data  = wdata[i];
            chk("s_ready_in_write", 32'(s_ready), 32'd1);
            wq.push_back('{a: 5'(a), d: wdata[i]});
            model[a] = wdata[i];
            step();
            if (i == gap_after) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                step(gap_len);
            end else if (rand_gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                step($urandom_range(1, 3));
            end
        end
        s_valid = 1'b0;
        wait_done("wr_done", 10, cyc);
        chk("wr_idle_after", 32'(busy), 32'd0);
    endtask

    task automatic read_burst(input logic [4:0] b, input int l, input int budget, output int cyc);
        for (int i = 0; i < l; i++) rq.push_back(model[(int'(b) + i) % DEPTH]);
        issue(1'b0, b, 6'(l));
        exp_done++;
        wait_done("rd_done", budget, cyc);
        chk("rd_queue_drained", rq.size(), 0);
    endtask

    task automatic bad_start(input logic [5:0] l);
        issue(1'($urandom), 5'($urandom), l);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        step();
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_still_idle", 32'(busy), 32'd0);
        step(2);
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; len = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        #3 rst = 1'b0;
        step(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wr_rd", 32'(ram_wr_rd), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        rst = 1'b1;
        step(2);

        // Fill the whole RAM, then stream it back at full rate.
        wdata.delete();
        for (int i = 0; i < 32; i++) wdata.push_back(8'(10 + i));
        write_burst(5'd0, 32, -1, 0, 1'b0);
        m_ready = 1'b1;
        read_burst(5'd0, 32, 200, cyc);
        chk("rd_rate_1_per_3", 32'(cyc <= 3 * 32 + 2), 32'd1);

        // Wrap from address 31 to 0 inside a burst.
        wdata.delete();
        for (int i = 0; i < 4; i++) wdata.push_back(8'(8'hA1 + i));
        write_burst(5'd30, 4, -1, 0, 1'b0);
        chk("wrap_model_0", 32'(model[0]), 32'hA3);
        read_burst(5'd30, 4, 40, cyc);

        // Five idle cycles on s_valid after the first beat.
        wdata.delete();
        for (int i = 0; i < 3; i++) wdata.push_back(8'($urandom));
        write_burst(5'd12, 3, 0, 5, 1'b0);
        read_burst(5'd12, 3, 40, cyc);

        // Consumer stalls for ten cycles on the first beat.
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) rq.push_back(model[(7 + i) % DEPTH]);
        issue(1'b0, 5'd7, 6'd2);
        exp_done++;
        n = 0;
        while (!m_valid && n < 10) begin
            step();
            n++;
        end
        chk("stall_valid_seen", 32'(m_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid_held", 32'(m_valid), 32'd1);
            step();
        end
        m_ready = 1'b1;
        wait_done("stall_done", 40, cyc);
        chk("stall_no_loss", rq.size(), 0);

        bad_start(6'd0);
        bad_start(6'd33);

        // Reset while beat 5 of a 16-beat write is on the bus.
        wdata.delete();
        for (int i = 0; i < 16; i++) wdata.push_back(8'($urandom));
        issue(1'b1, 5'd20, 6'd16);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = wdata[i];
            wq.push_back('{a: 5'((20 + i) % DEPTH), d: wdata[i]});
            model[(20 + i) % DEPTH] = wdata[i];
            step();
        end
        s_valid = 1'b1;
        s_data  = wdata[5];
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
        chk("abort_wr_rd", 32'(ram_wr_rd), 32'd0);
        chk("abort_addr", 32'(ram_addr), 32'd0);
        chk("abort_data_in", 32'(ram_data_in), 32'd0);
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        step(2);
        s_valid = 1'b0;
        rst = 1'b1;
        step(3);
        chk("abort_no_done", done_cnt, exp_done);
        read_burst(5'd25, 11, 60, cyc);

        // Random bursts with random stream stalls.
        for (int k = 0; k < 12; k++) begin
            logic [4:0] b;
            int         l;
            b = 5'($urandom);
            l = $urandom_range(1, 32);
            if ($urandom_range(0, 1) == 1) begin
                wdata.delete();
                for (int i = 0; i < l; i++) wdata.push_back(8'($urandom));
                write_burst(b, l, -1, 0, 1'b1);
            end else begin
                rand_ready = 1'b1;
                read_burst(b, l, 2000, cyc);
                rand_ready = 1'b0;
                m_ready = 1'b1;
            end
        end

        step(3);
        chk("final_wq_empty", wq.size(), 0);
        chk("final_err_count", err_cnt, 2);
        chk("final_done_count", done_cnt, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
